// File: rtl/move_controller.sv
// Player movement sequencer on the 8x4 grid: rejects off-grid moves locally, asks the forbidden-move
// checker for in-grid moves, commits or reports blocked, then holds off new commands for a cooldown.
module move_controller #(
    parameter int unsigned START_X         = 7,
    parameter int unsigned START_Y         = 3,
    parameter int unsigned COOLDOWN_CYCLES = 25000000,
    parameter int unsigned CHECK_TIMEOUT   = 15
) (
    input  logic       clk_50MHz_i,
    input  logic       rst_async_la_i,
    input  logic [2:0] dir_i,
    input  logic       dir_valid_i,
    output logic       dir_ready_o,
    output logic       chk_req_o,
    output logic [2:0] chk_posx_o,
    output logic [1:0] chk_posy_o,
    output logic [2:0] chk_dir_o,
    input  logic       chk_ack_i,
    input  logic       chk_allow_i,
    output logic [2:0] posx_o,
    output logic [1:0] posy_o,
    output logic       moved_o,
    output logic       blocked_o,
    output logic [7:0] move_count_o,
    output logic       busy_o
);

    localparam int unsigned CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int unsigned TO_W = (CHECK_TIMEOUT > 1) ? $clog2(CHECK_TIMEOUT) : 1;
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(CHECK_TIMEOUT - 1);

    localparam logic [2:0] DIR_UP    = 3'b000;
    localparam logic [2:0] DIR_DOWN  = 3'b111;
    localparam logic [2:0] DIR_RIGHT = 3'b101;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_NONE  = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_COOLDOWN} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_posx, w_posx_nxt;
    logic [1:0]      r_posy, w_posy_nxt;
    logic [2:0]      r_chk_dir, w_chk_dir_nxt;
    logic            r_chk_req, w_chk_req_nxt;
    logic            r_moved, w_moved_nxt;
    logic            r_blocked, w_blocked_nxt;
    logic [7:0]      r_count, w_count_nxt;
    logic [CD_W-1:0] r_cd_cnt, w_cd_cnt_nxt;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;

    logic            w_in_move;
    logic            w_in_edge;
    logic [2:0]      w_tgt_x;
    logic [1:0]      w_tgt_y;

    always_comb begin
        w_in_move = 1'b1;
        w_in_edge = 1'b0;
        case (dir_i)
            DIR_UP:    w_in_edge = (r_posy == 2'd0);
            DIR_DOWN:  w_in_edge = (r_posy == 2'd3);
            DIR_RIGHT: w_in_edge = (r_posx == 3'd7);
            DIR_LEFT:  w_in_edge = (r_posx == 3'd0);
            default:   w_in_move = 1'b0;
        endcase
    end

    // Only in-grid directions ever get latched, so the target cannot wrap.
    always_comb begin
        w_tgt_x = r_posx;
        w_tgt_y = r_posy;
        case (r_chk_dir)
            DIR_UP:    w_tgt_y = r_posy - 2'd1;
            DIR_DOWN:  w_tgt_y = r_posy + 2'd1;
            DIR_RIGHT: w_tgt_x = r_posx + 3'd1;
            DIR_LEFT:  w_tgt_x = r_posx - 3'd1;
            default:   ;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_posx_nxt    = r_posx;
        w_posy_nxt    = r_posy;
        w_chk_dir_nxt = r_chk_dir;
        w_chk_req_nxt = r_chk_req;
        w_moved_nxt   = 1'b0;
        w_blocked_nxt = 1'b0;
        w_count_nxt   = r_count;
        w_cd_cnt_nxt  = r_cd_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        case (r_state)
            S_IDLE: begin
                if (dir_valid_i && w_in_move) begin
                    if (w_in_edge) begin
                        w_blocked_nxt = 1'b1;
                    end else begin
                        w_chk_dir_nxt = dir_i;
                        w_chk_req_nxt = 1'b1;
                        w_to_cnt_nxt  = '0;
                        w_state_nxt   = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (chk_ack_i) begin
                    w_chk_req_nxt = 1'b0;
                    if (chk_allow_i) begin
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_blocked_nxt = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_chk_req_nxt = 1'b0;
                    w_blocked_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            S_COMMIT: begin
                w_posx_nxt   = w_tgt_x;
                w_posy_nxt   = w_tgt_y;
                w_moved_nxt  = 1'b1;
                w_cd_cnt_nxt = '0;
                w_state_nxt  = S_COOLDOWN;
                if (r_count != 8'hFF) begin
                    w_count_nxt = r_count + 8'd1;
                end
            end
            S_COOLDOWN: begin
                if (r_cd_cnt == CD_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cd_cnt_nxt = r_cd_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Reset deassertion is expected to be synchronised to clk upstream.
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            r_state   <= S_IDLE;
            r_posx    <= 3'(START_X);
            r_posy    <= 2'(START_Y);
            r_chk_dir <= DIR_NONE;
            r_chk_req <= 1'b0;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
            r_count   <= 8'd0;
            r_cd_cnt  <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_posx    <= w_posx_nxt;
            r_posy    <= w_posy_nxt;
            r_chk_dir <= w_chk_dir_nxt;
            r_chk_req <= w_chk_req_nxt;
            r_moved   <= w_moved_nxt;
            r_blocked <= w_blocked_nxt;
            r_count   <= w_count_nxt;
            r_cd_cnt  <= w_cd_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    assign dir_ready_o  = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign chk_req_o    = r_chk_req;
    assign chk_posx_o   = r_posx;
    assign chk_posy_o   = r_posy;
    assign chk_dir_o    = r_chk_dir;
    assign posx_o       = r_posx;
    assign posy_o       = r_posy;
    assign moved_o      = r_moved;
    assign blocked_o    = r_blocked;
    assign move_count_o = r_count;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: table of single commands with a checker responder, expectations
// queued when a command is strobed and compared when the outcome pulse (or silence) is observed.
module tb_move_controller;

    localparam logic [2:0] DIR_UP    = 3'b000;
    localparam logic [2:0] DIR_DOWN  = 3'b111;
    localparam logic [2:0] DIR_RIGHT = 3'b101;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_NONE  = 3'b100;

    logic       clk;
    logic       rst_n;
    logic [2:0] dir_i;
    logic       dir_valid_i;
    logic       dir_ready_o;
    logic       chk_req_o;
    logic [2:0] chk_posx_o;
    logic [1:0] chk_posy_o;
    logic [2:0] chk_dir_o;
    logic       chk_ack_i;
    logic       chk_allow_i;
    logic [2:0] posx_o;
    logic [1:0] posy_o;
    logic       moved_o;
    logic       blocked_o;
    logic [7:0] move_count_o;
    logic       busy_o;

    move_controller #(
        .START_X(7), .START_Y(3), .COOLDOWN_CYCLES(4), .CHECK_TIMEOUT(15)
    ) dut (
        .clk_50MHz_i   (clk),
        .rst_async_la_i(rst_n),
        .dir_i         (dir_i),
        .dir_valid_i   (dir_valid_i),
        .dir_ready_o   (dir_ready_o),
        .chk_req_o     (chk_req_o),
        .chk_posx_o    (chk_posx_o),
        .chk_posy_o    (chk_posy_o),
        .chk_dir_o     (chk_dir_o),
        .chk_ack_i     (chk_ack_i),
        .chk_allow_i   (chk_allow_i),
        .posx_o        (posx_o),
        .posy_o        (posy_o),
        .moved_o       (moved_o),
        .blocked_o     (blocked_o),
        .move_count_o  (move_count_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] dir;
        logic [2:0] px;
        logic [1:0] py;
        int         ack_dly;   // negative: checker never answers
        logic       allow;
        logic [2:0] ex;
        logic [1:0] ey;
        logic       exp_moved;
        logic       exp_blocked;
        logic       exp_req;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] d, input logic [2:0] px, input logic [1:0] py,
                                input int dly, input logic al, input logic [2:0] ex,
                                input logic [1:0] ey, input logic mv, input logic bl,
                                input logic rq, input logic [7:0] cnt);
        vec_t v;
        v.dir = d; v.px = px; v.py = py; v.ack_dly = dly; v.allow = al;
        v.ex = ex; v.ey = ey; v.exp_moved = mv; v.exp_blocked = bl;
        v.exp_req = rq; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!dir_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", dir_ready_o, 1);
    endtask

    task automatic apply(input vec_t v, output int req_cycles);
        vec_t e;
        int   k = 0;
        int   budget = 0;
        int   low;
        bit   seen = 0;
        bit   req_seen = 0;
        req_cycles = 0;
        wait_ready();
        @(negedge clk);
        dir_i = v.dir;
        dir_valid_i = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        dir_valid_i = 1'b0;
        dir_i = DIR_NONE;
        while (!seen && budget < 40) begin
            if (moved_o || blocked_o) begin
                seen = 1'b1;
            end else begin
                if (chk_req_o) begin
                    if (!req_seen) begin
                        check("chk_posx", chk_posx_o, v.px);
                        check("chk_posy", chk_posy_o, v.py);
                        check("chk_dir", chk_dir_o, v.dir);
                    end
                    req_seen = 1'b1;
                    req_cycles++;
                    if (k == v.ack_dly) begin
                        chk_ack_i = 1'b1;
                        chk_allow_i = v.allow;
                    end
                    k++;
                end
                @(negedge clk);
                chk_ack_i = 1'b0;
                chk_allow_i = 1'b0;
                budget++;
            end
        end
        e = exp_q.pop_front();
        check("moved", moved_o, e.exp_moved);
        check("blocked", blocked_o, e.exp_blocked);
        check("req_seen", req_seen, e.exp_req);
        check("posx", posx_o, e.ex);
        check("posy", posy_o, e.ey);
        check("count", move_count_o, e.exp_cnt);
        if (moved_o) begin
            low = dir_ready_o ? 0 : 1;
            @(negedge clk);
            check("moved_width", moved_o, 0);
            while (!dir_ready_o && low < 20) begin
                low++;
                @(negedge clk);
            end
            check("cooldown_len", low, 4);
        end else if (blocked_o) begin
            @(negedge clk);
            check("blocked_width", blocked_o, 0);
            check("ready_after_block", dir_ready_o, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        vec_t v;
        rst_n = 1'b0;
        dir_i = DIR_NONE;
        dir_valid_i = 1'b0;
        chk_ack_i = 1'b0;
        chk_allow_i = 1'b0;

        tbl[0] = mk(DIR_RIGHT, 3'd7, 2'd3, 0, 1'b0, 3'd7, 2'd3, 1'b0, 1'b1, 1'b0, 8'd0);
        tbl[1] = mk(DIR_DOWN,  3'd7, 2'd3, 0, 1'b0, 3'd7, 2'd3, 1'b0, 1'b1, 1'b0, 8'd0);
        tbl[2] = mk(DIR_NONE,  3'd7, 2'd3, 0, 1'b0, 3'd7, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0);
        tbl[3] = mk(3'b001,    3'd7, 2'd3, 0, 1'b0, 3'd7, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0);
        tbl[4] = mk(DIR_LEFT,  3'd7, 2'd3, 2, 1'b1, 3'd6, 2'd3, 1'b1, 1'b0, 1'b1, 8'd1);
        tbl[5] = mk(DIR_UP,    3'd6, 2'd3, 1, 1'b0, 3'd6, 2'd3, 1'b0, 1'b1, 1'b1, 8'd1);
        tbl[6] = mk(DIR_UP,    3'd6, 2'd3, 0, 1'b1, 3'd6, 2'd2, 1'b1, 1'b0, 1'b1, 8'd2);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_posx", posx_o, 7);
        check("rst_posy", posy_o, 3);
        check("rst_count", move_count_o, 0);
        check("rst_ready", dir_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_req", chk_req_o, 0);
        check("rst_chk_dir", chk_dir_o, DIR_NONE);
        check("rst_moved", moved_o, 0);
        check("rst_blocked", blocked_o, 0);

        for (int i = 0; i < 7; i++) apply(tbl[i], rc);

        // Checker never answers: request must stay up exactly 15 cycles.
        apply(mk(DIR_DOWN, 3'd6, 2'd2, -1, 1'b0, 3'd6, 2'd2, 1'b0, 1'b1, 1'b1, 8'd2), rc);
        check("timeout_req_cycles", rc, 15);
        repeat (3) begin
            chk_ack_i = 1'b1;
            chk_allow_i = 1'b1;
            @(negedge clk);
            check("late_ack_moved", moved_o, 0);
        end
        chk_ack_i = 1'b0;
        chk_allow_i = 1'b0;
        @(negedge clk);
        check("late_ack_posy", posy_o, 2);
        check("late_ack_count", move_count_o, 2);
        check("late_ack_ready", dir_ready_o, 1);
        check("late_ack_req", chk_req_o, 0);

        // Reset while a check is outstanding.
        @(negedge clk);
        dir_i = DIR_UP;
        dir_valid_i = 1'b1;
        @(negedge clk);
        dir_valid_i = 1'b0;
        dir_i = DIR_NONE;
        check("mid_check_req", chk_req_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", chk_req_o, 0);
        check("arst_posx", posx_o, 7);
        check("arst_posy", posy_o, 3);
        check("arst_count", move_count_o, 0);
        check("arst_busy", busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 256 allowed moves: counter saturates at 255.
        for (int i = 0; i < 256; i++) begin
            v = mk((i % 2 == 0) ? DIR_LEFT : DIR_RIGHT,
                   (i % 2 == 0) ? 3'd7 : 3'd6, 2'd3, 0, 1'b1,
                   (i % 2 == 0) ? 3'd6 : 3'd7, 2'd3, 1'b1, 1'b0, 1'b1,
                   (i < 255) ? 8'(i + 1) : 8'd255);
            apply(v, rc);
        end
        for (int i = 0; i < 3; i++) begin
            apply(mk(DIR_UP, 3'd7, 2'(3 - i), 0, 1'b1, 3'd7, 2'(2 - i),
                     1'b1, 1'b0, 1'b1, 8'd255), rc);
        end
        apply(mk(DIR_UP, 3'd7, 2'd0, 0, 1'b1, 3'd7, 2'd0, 1'b0, 1'b1, 1'b0, 8'd255), rc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Sequences player movement on the 8x4 room grid.
- Accepts one direction command at a time from the input decoder and rejects moves off the grid edge locally.
- For in-grid moves, runs a request/acknowledge transaction with the forbidden-move checker, then commits the new position or reports the move as blocked.
- Enforces a post-move cooldown and keeps a saturating move counter for the display/score logic.

Parameters:
- START_X, 7, x coordinate loaded on reset (0..7).
- START_Y, 3, y coordinate loaded on reset (0..3).
- COOLDOWN_CYCLES, 25000000, number of cycles dir_ready_o stays low after a committed move (0.5 s at 50 MHz); must be ≥1.
- CHECK_TIMEOUT, 15, maximum cycles to wait for chk_ack_i before treating the move as blocked.

Ports:
- clk_50MHz_i  in  1  system clock, rising edge.
- rst_async_la_i  in  1  asynchronous active-low reset.
- dir_i  in  3  direction code: UP=000, DOWN=111, RIGHT=101, LEFT=010, NONE=100; other codes are invalid.
- dir_valid_i  in  1  command strobe; accepted when high together with dir_ready_o.
- dir_ready_o  out  1  high only in IDLE.
- chk_req_o  out  1  check request to the forbidden-move checker.
- chk_posx_o  out  3  current x coordinate presented to the checker.
- chk_posy_o  out  2  current y coordinate presented to the checker.
- chk_dir_o  out  3  latched direction presented to the checker.
- chk_ack_i  in  1  checker response valid.
- chk_allow_i  in  1  1 = move permitted; sampled only while chk_ack_i is high.
- posx_o  out  3  committed x coordinate.
- posy_o  out  2  committed y coordinate.
- moved_o  out  1  one-cycle pulse on commit.
- blocked_o  out  1  one-cycle pulse on any rejection.
- move_count_o  out  8  number of committed moves, saturates at 255.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State IDLE, posx_o=START_X, posy_o=START_Y.
  - move_count_o=0, chk_req_o=0, moved_o=0, blocked_o=0.
  - dir_ready_o=1, busy_o=0, chk_dir_o=NONE.
  - Assertion in any state aborts the operation in progress; chk_req_o drops asynchronously.
- Target computation:
  - UP: y-1. DOWN: y+1. RIGHT: x+1. LEFT: x-1.
  - A move is an edge case when it would leave the grid, i.e. UP at y=0, DOWN at y=3, LEFT at x=0, RIGHT at x=7. Coordinates never wrap.
- IDLE: acceptance on edge T0 when dir_valid_i=1.
  - NONE or invalid code: command is dropped, state stays IDLE, no pulses.
  - Edge case: blocked_o=1 during cycle T0+1, state stays IDLE, chk_req_o is never asserted.
  - Otherwise: latch dir_i into chk_dir_o, set chk_req_o=1 from T0+1, go to CHECK.
- CHECK:
  - chk_req_o, chk_posx_o, chk_posy_o and chk_dir_o are held stable.
  - The timeout counter increments every cycle.
  - On the first edge where chk_ack_i=1 and chk_allow_i=1: go to COMMIT.
  - On the first edge where chk_ack_i=1 and chk_allow_i=0: blocked_o pulses the next cycle, chk_req_o=0, go to IDLE.
  - No ack within CHECK_TIMEOUT cycles: same response as a deny.
  - chk_req_o is deasserted the cycle after the ack is sampled.
- COMMIT (one cycle):
  - posx_o/posy_o take the target value and moved_o=1.
  - move_count_o increments, holding at 255.
  - Go to COOLDOWN.
- COOLDOWN:
  - Counts COOLDOWN_CYCLES cycles, then returns to IDLE.
  - dir_valid_i is ignored; commands are not queued.
- dir_valid_i arriving in any non-IDLE state is discarded.
- chk_ack_i arriving outside CHECK is ignored.
- Latency for an allowed move: ack sampled at edge T1 → posx_o/posy_o updated and moved_o high after edge T1+1 → dir_ready_o returns high COOLDOWN_CYCLES cycles later.

Test Plan:
- Release reset → posx_o=7, posy_o=3, move_count_o=0, dir_ready_o=1, chk_req_o=0.
- COOLDOWN_CYCLES=4. At (7,3), strobe LEFT; checker acks allow 2 cycles after chk_req_o rises → chk_posx_o=7, chk_dir_o=010 during CHECK; then posx_o=6, moved_o high for exactly 1 cycle, move_count_o=1, dir_ready_o low for 4 cycles after COMMIT.
- At (7,3), strobe RIGHT → blocked_o 1-cycle pulse, chk_req_o stays 0, position unchanged. Strobe NONE → no pulses, no state change.
- At (6,3), strobe UP; checker acks deny → blocked_o pulse, posy_o=3, move_count_o unchanged, dir_ready_o=1 the cycle after the pulse.
- Strobe DOWN at (6,2) with chk_ack_i held low → blocked_o pulses after 15 cycles, then chk_req_o=0. A late ack arriving afterwards has no effect.
- Assert reset while in CHECK with chk_req_o=1 → chk_req_o=0 immediately, position back to (7,3). Separately, 256 allowed moves → move_count_o holds at 255.
